// File: rtl/arbiter_wrr_n.sv
// N-way weighted round-robin arbiter.
// Each grant holds the shared resource for up to W[owner] cycles while others
// contend, then rotates priority to the next requester after the owner.
// Weights are runtime-programmable through a single-cycle write port.
module arbiter_wrr_n #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [CW-1:0] cfg_weight,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_valid,
  output logic [CW-1:0] credit
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] weight_q [N];
  logic [CW-1:0] weight_d [N];

  // Round-robin search result and load control.
  logic          rr_found;
  logic [IW-1:0] rr_idx;
  logic          others_req;
  logic          load;
  logic [IW-1:0] load_idx;

  // A stored weight of zero behaves as a one-cycle quota.
  function automatic logic [CW-1:0] eff_weight(input logic [CW-1:0] w);
    return (w == '0) ? CW'(1) : w;
  endfunction

  // Pointer to the requester following idx, wrapping at N.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
  endfunction

  // Find the first requester at or after the pointer, wrapping around.
  always_comb begin
    int j;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!rr_found && req[IW'(j)]) begin
        rr_found = 1'b1;
        rr_idx   = IW'(j);
      end
    end
  end

  // Requests from anyone other than the current owner (gnt_q is its one-hot mask).
  assign others_req = |(req & ~gnt_q);

  // Next-state logic: decide whether to load a new quota, count down, or go idle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    weight_d = weight_q;
    load     = 1'b0;
    load_idx = rr_idx;

    unique case (state_q)
      S_IDLE: begin
        if (rr_found) load = 1'b1;
      end
      S_GRANT: begin
        if (!req[gnt_id_q]) begin
          // Owner released: hand over with no bubble, or fall idle.
          if (rr_found) begin
            load = 1'b1;
          end else begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            credit_d = '0;
          end
        end else if (credit_q == CW'(1)) begin
          // Quota spent: rotate if anyone else waits (the pointer already sits
          // past the owner, so the search cannot pick it), otherwise reload.
          load = 1'b1;
          if (!others_req) load_idx = gnt_id_q;
        end else begin
          credit_d = credit_q - CW'(1);
        end
      end
      default: ;
    endcase

    if (load) begin
      state_d  = S_GRANT;
      gnt_id_d = load_idx;
      gnt_d    = N'(1) << load_idx;
      // Loads read the pre-write weight, so a same-cycle cfg write lands next time.
      credit_d = eff_weight(weight_q[load_idx]);
      ptr_d    = next_idx(load_idx);
    end

    if (cfg_we && (int'(cfg_idx) < N)) weight_d[cfg_idx] = cfg_weight;
  end

  // State, output and weight registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      credit_q <= '0;
      ptr_q    <= '0;
      // NOTE: the weight table is small register storage, not RAM, so it is reset to pure round-robin.
      for (int i = 0; i < N; i++) weight_q[i] <= CW'(1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      weight_q <= weight_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = (state_q == S_GRANT);
  assign credit    = credit_q;

endmodule

// File: tb/tb_arbiter_wrr_n.sv
// Self-checking bench for arbiter_wrr_n: directed scenarios followed by
// randomized requests and weight writes, compared each cycle against a
// behavioural model that tracks owner, quota and cycles used.
module tb_arbiter_wrr_n;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [CW-1:0] cfg_weight;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic [CW-1:0] credit;

  arbiter_wrr_n #(.N(N), .CW(CW), .IW(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid),
    .credit     (credit)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns, how long the current quota is, how much is used.
  bit m_valid;
  int m_owner, m_quota, m_used, m_ptr;
  int m_w [N];

  function automatic int eff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic m_reset();
    m_valid = 0; m_owner = 0; m_quota = 0; m_used = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_w[i] = 1;
  endtask

  function automatic int m_rr(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_grant(input int k);
    m_valid = 1; m_owner = k; m_quota = eff(m_w[k]); m_used = 0; m_ptr = (k + 1) % N;
  endtask

  task automatic m_step(input logic [N-1:0] r, input bit we, input int idx, input int w);
    logic [N-1:0] others;
    if (!m_valid) begin
      if (r != 0) m_grant(m_rr(r));
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (r != 0) m_grant(m_rr(r));
        else m_valid = 0;
      end else if (m_quota - m_used == 1) begin
        if (others != 0) m_grant(m_rr(r));
        else m_grant(m_owner);
      end else begin
        m_used++;
      end
    end
    if (we && idx < N) m_w[idx] = w;
  endtask

  task automatic compare();
    check("gnt",       32'(gnt),       m_valid ? (32'd1 << m_owner) : 32'd0);
    check("gnt_valid", 32'(gnt_valid), 32'(m_valid));
    check("credit",    32'(credit),    m_valid ? 32'(m_quota - m_used) : 32'd0);
    if (m_valid) check("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  // Drive one cycle of inputs, clock it, update the model, then sample.
  task automatic step(input logic [N-1:0] r, input bit we = 1'b0, input int idx = 0, input int w = 0);
    req        = r;
    cfg_we     = we;
    cfg_idx    = idx[IW-1:0];
    cfg_weight = w[CW-1:0];
    @(posedge clk);
    m_step(r, we, idx, w);
    #1;
    cfg_we = 1'b0;
    compare();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    32'(gnt),       32'd0);
    check({tag, "_valid"},  32'(gnt_valid), 32'd0);
    check({tag, "_credit"}, 32'(credit),    32'd0);
    check({tag, "_id"},     32'(gnt_id),    32'd0);
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b0; req = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_weight = '0;
    m_reset();
    @(posedge clk); #1;
    check_zero("reset");
    rst = 1'b1;

    // Single requester holds forever via the reload path.
    step(4'b0000);
    for (int i = 0; i < 6; i++) step(4'b0100);

    // All requesting with unit weights: one cycle each in rotation.
    for (int i = 0; i < 10; i++) step(4'b1111);

    // Weighted pair: 3 cycles for requester 0, 1 cycle for requester 1.
    step(4'b0000, 1'b1, 0, 3);
    step(4'b0000, 1'b1, 1, 1);
    for (int i = 0; i < 12; i++) step(4'b0011);

    // Owner release hands over with no bubble; dropping all goes idle.
    step(4'b0000, 1'b1, 0, 4);
    step(4'b0001);
    step(4'b0011);
    step(4'b0010);
    step(4'b0010);
    step(4'b0000);
    step(4'b0000);

    // Weight rewritten mid-quota only affects the next load.
    step(4'b0000, 1'b1, 0, 5);
    step(4'b0011);
    step(4'b0011);
    step(4'b0011, 1'b1, 0, 2);
    for (int i = 0; i < 10; i++) step(4'b0011);
    step(4'b0011, 1'b1, 0, 0);
    for (int i = 0; i < 8; i++) step(4'b0011);

    // Asynchronous reset mid-grant, then pointer restarts at requester 0.
    step(4'b0000);
    step(4'b0100);
    step(4'b0100);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    m_reset();
    @(posedge clk); #1;
    check_zero("rst_held");
    rst = 1'b1;
    step(4'b1010);
    check("first_after_rst", 32'(gnt), 32'b0010);
    for (int i = 0; i < 4; i++) step(4'b1010);

    // Randomized requests and weight writes.
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      if ($urandom_range(0, 9) == 0)
        step(r, 1'b1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 7)));
      else
        step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
